// File: rtl/serial_magnitude_cmp.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, start/busy/done handshake.
// Define SIGNED_CMP_EN to compare the operands as two's complement instead of unsigned.
module serial_magnitude_cmp #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             in_clk,
   input  logic             in_reset,
   input  logic             in_start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_mode,
   output logic             out_busy,
   output logic             out_done,
   output logic             out_s,
   output logic             out_lt,
   output logic             out_gt,
   output logic             out_eq
);
   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2:0]         r_mode;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_s;
   logic               r_lt;
   logic               r_gt;
   logic               r_eq;

   logic [DIGIT-1:0]   w_da;
   logic [DIGIT-1:0]   w_db;
   logic               w_decide;
   logic               w_lt;
   logic               w_gt;
   logic               w_eq;

   function automatic logic f_select(input logic [2:0] mode, input logic lt,
                                     input logic gt, input logic eq);
      case (mode)
         3'd0:    f_select = lt;
         3'd1:    f_select = gt;
         3'd2:    f_select = eq;
         3'd3:    f_select = ~eq;
         3'd4:    f_select = lt | eq;
         3'd5:    f_select = gt | eq;
         default: f_select = 1'b0;
      endcase
   endfunction

   assign w_da = DIGIT'(r_a >> (int'(r_cnt) * DIGIT));
   assign w_db = DIGIT'(r_b >> (int'(r_cnt) * DIGIT));

   // Digit decision: first differing digit (or sign mismatch on the first digit) ends the scan.
   always_comb begin
      w_decide = 1'b0;
      w_lt     = 1'b0;
      w_gt     = 1'b0;
      w_eq     = 1'b0;
`ifdef SIGNED_CMP_EN
      if ((r_cnt == CNT_W'(NDIG - 1)) && (r_a[WIDTH-1] != r_b[WIDTH-1])) begin
         w_decide = 1'b1;
         w_lt     = r_a[WIDTH-1];
         w_gt     = r_b[WIDTH-1];
      end else
`endif
      if (w_da != w_db) begin
         w_decide = 1'b1;
         w_lt     = (w_da < w_db);
         w_gt     = (w_da > w_db);
      end else if (r_cnt == '0) begin
         w_decide = 1'b1;
         w_eq     = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_start) w_state_nxt = S_SCAN;
         S_SCAN:  if (w_decide) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = in_start ? S_SCAN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         r_a    <= '0;
         r_b    <= '0;
         r_mode <= '0;
         r_cnt  <= '0;
         r_s    <= 1'b0;
         r_lt   <= 1'b0;
         r_gt   <= 1'b0;
         r_eq   <= 1'b0;
      end else if (r_state == S_SCAN) begin
         if (w_decide) begin
            r_lt <= w_lt;
            r_gt <= w_gt;
            r_eq <= w_eq;
            r_s  <= f_select(r_mode, w_lt, w_gt, w_eq);
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end else if (in_start) begin
         r_a    <= in_a;
         r_b    <= in_b;
         r_mode <= in_mode;
         r_cnt  <= CNT_W'(NDIG - 1);
      end
   end

   assign out_busy = (r_state == S_SCAN);
   assign out_done = (r_state == S_DONE);
   assign out_s    = r_s;
   assign out_lt   = r_lt;
   assign out_gt   = r_gt;
   assign out_eq   = r_eq;
endmodule
